// File: rtl/phy_tx_pkg.sv
// Shared PHY transmit definitions: ordered-set symbols, bus width codes,
// framer state encoding and the lanes-per-word helper used by MAC and PCS.
package phy_tx_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_0 = 8'h1C;

   localparam logic [5:0] WIDTH_8  = 6'd8;
   localparam logic [5:0] WIDTH_16 = 6'd16;
   localparam logic [5:0] WIDTH_32 = 6'd32;

   typedef enum logic {
      PACK = 1'b0,
      SKP  = 1'b1
   } tx_state_t;

   // Unsupported width codes fall back to a single lane.
   function automatic logic [2:0] lane_count(input logic [5:0] width);
      case (width)
         WIDTH_16: return 3'd2;
         WIDTH_32: return 3'd4;
         default:  return 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/tx_byte_packer.sv
// Byte-to-word packer: collects accepted bytes into lanes of a partial word
// and holds the registered output word chosen by the framer.
module tx_byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  lanes,
   input  logic        accept,
   input  logic [7:0]  sym_data,
   input  logic        sym_k,
   output logic [2:0]  fill,
   output logic        complete,
   output logic [31:0] asm_data,
   output logic [3:0]  asm_k,
   input  logic [31:0] load_data,
   input  logic [3:0]  load_k,
   input  logic        load_en,
   output logic [31:0] word_data,
   output logic [3:0]  word_k,
   output logic        word_en
);

   logic [23:0] hold_data;
   logic [2:0]  hold_k;

   assign complete = accept && ((fill + 3'd1) == lanes);

   // Lanes above the fill point stay zero, so a completed word never carries stale bytes.
   always_comb begin
      asm_data = {8'h00, hold_data};
      asm_k    = {1'b0, hold_k};
      asm_data[{fill[1:0], 3'b000} +: 8] = sym_data;
      asm_k[fill[1:0]]                   = sym_k;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill      <= 3'd0;
         hold_data <= '0;
         hold_k    <= '0;
         word_data <= '0;
         word_k    <= '0;
         word_en   <= 1'b0;
      end else begin
         if (accept) begin
            if (complete) begin
               fill      <= 3'd0;
               hold_data <= '0;
               hold_k    <= '0;
            end else begin
               fill      <= fill + 3'd1;
               hold_data <= asm_data[23:0];
               hold_k    <= asm_k[2:0];
            end
         end
         word_data <= load_data;
         word_k    <= load_k;
         word_en   <= load_en;
      end
   end

endmodule

// File: rtl/mac_tx_framer.sv
// MAC-to-PHY transmit framer: packs bytes into 8/16/32-bit words and, when
// TX_SKP_INSERT_EN is defined, periodically inserts COM+3xSKP ordered sets.
module mac_tx_framer
   import phy_tx_pkg::*;
#(
   parameter int SKP_INTERVAL = 1180
) (
   input  logic        PCLK,
   input  logic        RST,
   input  logic [5:0]  DataBusWidth,
   input  logic [7:0]  in_data,
   input  logic        in_k,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] MAC_TX_Data,
   output logic [3:0]  MAC_TX_DataK,
   output logic        MAC_Data_En
);

   logic [5:0]  width_q;
   logic [2:0]  lanes;
   logic [2:0]  fill;
   logic        accept;
   logic        complete;
   logic        pack_idle;
   logic [31:0] asm_data;
   logic [3:0]  asm_k;
   logic        skp_load;
   logic [31:0] skp_data;
   logic [3:0]  skp_k;
   logic [31:0] out_data;
   logic [3:0]  out_k;
   logic        out_en;

   assign accept = in_valid && in_ready;

`ifdef TX_SKP_INSERT_EN
   localparam logic [11:0] INTERVAL = 12'(SKP_INTERVAL);

   tx_state_t   state, state_next;
   logic [11:0] sym_cnt, sym_next;
   logic        skp_pend, pend_next;
   logic [1:0]  skp_idx, skp_idx_next, skp_last_idx;
   logic        fill_zero_next;

   function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [2:0] b);
      logic [12:0] s;
      s = {1'b0, a} + {10'd0, b};
      return s[12] ? 12'hFFF : s[11:0];
   endfunction

   assign pack_idle      = (state == PACK) && (fill == 3'd0);
   assign skp_load       = (state == SKP);
   assign fill_zero_next = complete || ((fill == 3'd0) && !accept);

   always_comb begin
      case (lanes)
         3'd4:    skp_last_idx = 2'd0;
         3'd2:    skp_last_idx = 2'd1;
         default: skp_last_idx = 2'd3;
      endcase
   end

   // COM only ever lands in lane 0 of the first SKP word; every other active lane is SKP.
   always_comb begin
      skp_data = '0;
      skp_k    = '0;
      for (int l = 0; l < 4; l++) begin
         if (3'(l) < lanes) begin
            skp_data[8*l +: 8] = K28_0;
            skp_k[l]           = 1'b1;
         end
      end
      if (skp_idx == 2'd0) skp_data[7:0] = K28_5;
   end

   always_comb begin
      state_next   = state;
      sym_next     = sym_cnt;
      pend_next    = skp_pend;
      skp_idx_next = skp_idx;
      case (state)
         PACK: begin
            if (complete) sym_next = sat_add(sym_cnt, lanes);
            pend_next = skp_pend || (sym_next >= INTERVAL);
            if (pend_next && fill_zero_next) begin
               state_next   = SKP;
               skp_idx_next = 2'd0;
            end
         end
         SKP: begin
            if (skp_idx == skp_last_idx) begin
               state_next   = PACK;
               sym_next     = 12'd0;
               pend_next    = 1'b0;
               skp_idx_next = 2'd0;
            end else begin
               skp_idx_next = skp_idx + 2'd1;
            end
         end
         default: state_next = PACK;
      endcase
   end

   always_ff @(posedge PCLK or posedge RST) begin
      if (RST) begin
         state    <= PACK;
         sym_cnt  <= 12'd0;
         skp_pend <= 1'b0;
         skp_idx  <= 2'd0;
         in_ready <= 1'b0;
      end else begin
         state    <= state_next;
         sym_cnt  <= sym_next;
         skp_pend <= pend_next;
         skp_idx  <= skp_idx_next;
         in_ready <= (state_next == PACK);
      end
   end
`else
   logic unused_interval;

   assign unused_interval = ^SKP_INTERVAL;
   assign pack_idle       = (fill == 3'd0);
   assign skp_load        = 1'b0;
   assign skp_data        = '0;
   assign skp_k           = '0;

   always_ff @(posedge PCLK or posedge RST) begin
      if (RST) in_ready <= 1'b0;
      else     in_ready <= 1'b1;
   end
`endif

   // A width change only takes effect when a fresh word is about to start.
   assign lanes = lane_count(pack_idle ? DataBusWidth : width_q);

   always_ff @(posedge PCLK or posedge RST) begin
      if (RST)            width_q <= WIDTH_8;
      else if (pack_idle) width_q <= DataBusWidth;
   end

   always_comb begin
      out_data = '0;
      out_k    = '0;
      out_en   = 1'b0;
      if (skp_load) begin
         out_data = skp_data;
         out_k    = skp_k;
         out_en   = 1'b1;
      end else if (complete) begin
         out_data = asm_data;
         out_k    = asm_k;
         out_en   = 1'b1;
      end
   end

   tx_byte_packer u_packer (
      .clk       (PCLK),
      .rst       (RST),
      .lanes     (lanes),
      .accept    (accept),
      .sym_data  (in_data),
      .sym_k     (in_k),
      .fill      (fill),
      .complete  (complete),
      .asm_data  (asm_data),
      .asm_k     (asm_k),
      .load_data (out_data),
      .load_k    (out_k),
      .load_en   (out_en),
      .word_data (MAC_TX_Data),
      .word_k    (MAC_TX_DataK),
      .word_en   (MAC_Data_En)
   );

endmodule

// File: tb/tb_mac_tx_framer.sv
// Self-checking bench for mac_tx_framer: directed phases plus a randomized
// stream, every cycle compared against a symbol-level reference model.
module tb_mac_tx_framer;

   localparam int INTERVAL = 8;
`ifdef TX_SKP_INSERT_EN
   localparam bit SKP_EN = 1'b1;
`else
   localparam bit SKP_EN = 1'b0;
`endif

   logic        PCLK = 1'b0;
   logic        RST  = 1'b1;
   logic [5:0]  DataBusWidth = 6'd8;
   logic [7:0]  in_data  = 8'h00;
   logic        in_k     = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] MAC_TX_Data;
   logic [3:0]  MAC_TX_DataK;
   logic        MAC_Data_En;

   mac_tx_framer #(.SKP_INTERVAL(INTERVAL)) dut (
      .PCLK         (PCLK),
      .RST          (RST),
      .DataBusWidth (DataBusWidth),
      .in_data      (in_data),
      .in_k         (in_k),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .MAC_TX_Data  (MAC_TX_Data),
      .MAC_TX_DataK (MAC_TX_DataK),
      .MAC_Data_En  (MAC_Data_En)
   );

   always #5 PCLK = ~PCLK;

   int checks = 0;
   int errors = 0;

   // Reference model: byte buffer, symbol count and remaining ordered-set words.
   logic [7:0]  m_bytes [4];
   logic        m_ks    [4];
   int          m_fill, m_L, m_sym, m_skp_left, m_skp_n, m_skp_L;
   logic        m_ready;
   logic [31:0] exp_data;
   logic [3:0]  exp_k;
   logic        exp_en;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lanes_of(input logic [5:0] w);
      case (w)
         6'd16:   return 2;
         6'd32:   return 4;
         default: return 1;
      endcase
   endfunction

   task automatic model_reset();
      m_fill = 0; m_L = 1; m_sym = 0; m_skp_left = 0; m_skp_n = 0; m_skp_L = 1;
      m_ready = 1'b0;
      exp_data = '0; exp_k = '0; exp_en = 1'b0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] d, input bit k);
      bit hs;
      int idx;
      hs = v && m_ready;
      exp_data = '0; exp_k = '0; exp_en = 1'b0;
      if (m_skp_left > 0) begin
         idx = m_skp_n - m_skp_left;
         for (int l = 0; l < m_skp_L; l++) begin
            exp_data[8*l +: 8] = ((idx * m_skp_L + l) == 0) ? 8'hBC : 8'h1C;
            exp_k[l] = 1'b1;
         end
         exp_en = 1'b1;
         m_skp_left--;
      end else if (hs) begin
         if (m_fill == 0) m_L = lanes_of(DataBusWidth);
         m_bytes[m_fill] = d;
         m_ks[m_fill]    = k;
         m_fill++;
         if (m_fill == m_L) begin
            for (int l = 0; l < m_L; l++) begin
               exp_data[8*l +: 8] = m_bytes[l];
               exp_k[l] = m_ks[l];
            end
            exp_en = 1'b1;
            m_fill = 0;
            m_sym  = (m_sym + m_L > 4095) ? 4095 : m_sym + m_L;
            if (SKP_EN && m_sym >= INTERVAL) begin
               m_skp_n    = 4 / m_L;
               m_skp_left = m_skp_n;
               m_skp_L    = m_L;
               m_sym      = 0;
            end
         end
      end
      m_ready = (m_skp_left == 0);
   endtask

   // Called at a falling edge: drive, advance the model, then check one cycle later.
   task automatic cycle(input bit v, input logic [7:0] d, input bit k, input string tag);
      in_valid = v; in_data = d; in_k = k;
      model_step(v, d, k);
      @(negedge PCLK);
      check({tag, "_data"},  MAC_TX_Data,  exp_data);
      check({tag, "_k"},     MAC_TX_DataK, exp_k);
      check({tag, "_en"},    MAC_Data_En,  exp_en);
      check({tag, "_ready"}, in_ready,     m_ready);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_data"},  MAC_TX_Data,  32'h0);
      check({tag, "_k"},     MAC_TX_DataK, 4'h0);
      check({tag, "_en"},    MAC_Data_En,  1'b0);
      check({tag, "_ready"}, in_ready,     1'b0);
   endtask

   task automatic apply_reset(input string tag);
      @(negedge PCLK);
      in_valid = 1'b0;
      RST = 1'b1;
      #1;
      check_cleared(tag);
      model_reset();
      @(negedge PCLK);
      RST = 1'b0;
      cycle(1'b0, 8'h00, 1'b0, {tag, "_rel"});
   endtask

   logic [5:0] wsel [5] = '{6'd8, 6'd16, 6'd32, 6'd20, 6'd0};

   initial begin
      bit reached;
      model_reset();
      repeat (2) @(negedge PCLK);
      check_cleared("reset_hold");
      apply_reset("reset");

      DataBusWidth = 6'd8;
      cycle(1, 8'h11, 0, "w8_a");
      cycle(1, 8'h22, 0, "w8_b");
      cycle(1, 8'h33, 0, "w8_c");
      repeat (3) cycle(0, 8'h00, 0, "w8_idle");

      apply_reset("rst2");
      DataBusWidth = 6'd32;
      cycle(1, 8'h01, 0, "w32_0");
      cycle(1, 8'h02, 0, "w32_1");
      cycle(1, 8'hBC, 1, "w32_2");
      cycle(1, 8'h04, 0, "w32_3");
      repeat (3) cycle(0, 8'h00, 0, "w32_idle");

      apply_reset("rst3");
      DataBusWidth = 6'd16;
      for (int i = 0; i < 26; i++) cycle(1, 8'($urandom), 0, "w16_stream");
      repeat (3) cycle(0, 8'h00, 0, "w16_idle");

      apply_reset("rst4");
      DataBusWidth = 6'd32;
      for (int i = 0; i < 4; i++) cycle(1, 8'(8'h40 + i), 0, "w32_word1");
      cycle(1, 8'hA0, 0, "w32_part");
      cycle(1, 8'hA1, 0, "w32_part");
      repeat (3) cycle(0, 8'h00, 0, "w32_gap");
      cycle(1, 8'hA2, 0, "w32_part");
      cycle(1, 8'hA3, 0, "w32_part");
      repeat (4) cycle(0, 8'h00, 0, "w32_skp");

      apply_reset("rst5");
      DataBusWidth = 6'd8;
      reached = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         cycle(1, 8'($urandom), 0, "w8_to_skp");
         reached = (m_skp_left == 3);
      end
      if (SKP_EN) begin
         check("skp_reached", reached, 1'b1);
         in_valid = 1'b0;
         #2 RST = 1'b1;
         #1 check_cleared("mid_skp_rst");
         model_reset();
         @(negedge PCLK);
         check_cleared("mid_skp_hold");
         RST = 1'b0;
         cycle(0, 8'h00, 0, "mid_skp_rel");
         cycle(1, 8'h55, 0, "after_rst_55");
         repeat (6) cycle(0, 8'h00, 0, "after_rst_idle");
      end

      apply_reset("rst6");
      DataBusWidth = 6'd20;
      cycle(1, 8'hAA, 0, "w20_a");
      cycle(1, 8'hBB, 0, "w20_b");
      repeat (2) cycle(0, 8'h00, 0, "w20_idle");

      apply_reset("rst7");
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) DataBusWidth = wsel[$urandom_range(0, 4)];
         cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 7) == 0), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached without completing");
      $fatal(1);
   end

endmodule
